// File: rtl/oai_mac_array.sv
// oai_mac_array: bit-serial multiply-accumulate over N_CH channels of OAI bit multipliers, two weight rows.
// Optional macro OAI_MAC_ZSKIP_EN: an all-zero activation vector bypasses COMPUTE and returns 0 at once.
module oai_mac_array #(
    parameter int unsigned WW    = 12,
    parameter int unsigned N_CH  = 8,
    parameter int unsigned XW    = 8,
    parameter int unsigned ACC_W = WW + XW + $clog2(N_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    w_we,
    input  logic                    w_row,
    input  logic [$clog2(N_CH)-1:0] w_ch,
    input  logic [WW-1:0]           w_data,
    output logic                    w_err,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_CH*XW-1:0]      x_data,
    input  logic                    bank_sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_W-1:0]        out_data,
    output logic                    busy
);

    localparam int unsigned CH_W = $clog2(N_CH);
    localparam int unsigned TW   = WW + CH_W;
    localparam int unsigned KW   = (XW > 1) ? $clog2(XW) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t             state;
    state_t             state_d;

    logic [WW-1:0]      w0_q [N_CH];
    logic [WW-1:0]      w1_q [N_CH];
    logic [N_CH*XW-1:0] x_sr;
    logic               bank_q;
    logic [KW-1:0]      k_q;
    logic [ACC_W-1:0]   acc_q;

    logic               accept_c;
    logic               zero_c;
    logic               w_drop_c;
    logic [TW-1:0]      tree_c;
    logic [ACC_W-1:0]   acc_next_c;
    logic [WW-1:0]      oa_c;
    logic [WW-1:0]      ob_c;
    logic [WW-1:0]      nx_c;
    logic [WW-1:0]      e_c;

    logic               in_ready_d;
    logic               busy_d;
    logic               out_valid_d;
    logic [ACC_W-1:0]   out_data_d;

    assign accept_c = in_valid && in_ready;

`ifdef OAI_MAC_ZSKIP_EN
    assign zero_c = (x_data == '0);
`else
    assign zero_c = 1'b0;
`endif

    // A write targeting the row in use is dropped; on the accept edge the new bank is the one in use.
    assign w_drop_c = w_we && (((state != S_IDLE) && (w_row == bank_q)) ||
                               (accept_c && (w_row == bank_sel)));

    // Per-channel OAI bit product on the current activation bit, summed by the adder tree.
    always_comb begin
        tree_c = '0;
        oa_c   = '0;
        ob_c   = '0;
        nx_c   = '0;
        e_c    = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            nx_c   = {WW{~x_sr[i*XW + XW - 1]}};
            oa_c   = bank_q ? '1 : w0_q[i];
            ob_c   = bank_q ? w1_q[i] : '1;
            e_c    = ~((oa_c | nx_c) & (ob_c | nx_c));
            tree_c = tree_c + TW'(e_c);
        end
    end

    assign acc_next_c = (acc_q << 1) + ACC_W'(tree_c);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:    if (accept_c) state_d = zero_c ? S_DONE : S_COMPUTE;
            S_COMPUTE: if (k_q == '0) state_d = S_DONE;
            S_DONE:    if (out_valid && out_ready) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs
    always_comb begin
        in_ready_d  = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        out_valid_d = out_valid;
        out_data_d  = out_data;
        case (state)
            S_IDLE: begin
                if (accept_c && zero_c) begin
                    out_valid_d = 1'b1;
                    out_data_d  = '0;
                end
            end
            S_COMPUTE: begin
                if (k_q == '0) begin
                    out_valid_d = 1'b1;
                    out_data_d  = acc_next_c;
                end
            end
            S_DONE: begin
                if (out_valid && out_ready) out_valid_d = 1'b0;
            end
            default: out_valid_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            w_err     <= 1'b0;
        end else begin
            in_ready  <= in_ready_d;
            busy      <= busy_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            w_err     <= w_drop_c;
        end
    end

    // Datapath; shifting the whole vector is safe since only each channel's MSB is read within XW steps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_sr   <= '0;
            bank_q <= 1'b0;
            k_q    <= '0;
            acc_q  <= '0;
        end else if (accept_c) begin
            x_sr   <= x_data;
            bank_q <= bank_sel;
            k_q    <= KW'(XW - 1);
            acc_q  <= '0;
        end else if (state == S_COMPUTE) begin
            x_sr   <= x_sr << 1;
            k_q    <= k_q - KW'(1);
            acc_q  <= acc_next_c;
        end
    end

    // Weights held inverted; all-ones is a zero weight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                w0_q[i] <= '1;
                w1_q[i] <= '1;
            end
        end else if (w_we && !w_drop_c) begin
            if (w_row) w1_q[w_ch] <= ~w_data;
            else       w0_q[w_ch] <= ~w_data;
        end
    end

endmodule

// File: tb/tb_oai_mac_array.sv
// Scoreboard bench for oai_mac_array: directed scenarios plus randomized operations and weight writes.
`timescale 1ns/1ps
module tb_oai_mac_array;

    localparam int unsigned WW    = 12;
    localparam int unsigned N_CH  = 8;
    localparam int unsigned XW    = 8;
    localparam int unsigned CW    = $clog2(N_CH);
    localparam int unsigned ACC_W = WW + XW + CW;
    localparam int unsigned XV    = N_CH * XW;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             w_we = 1'b0;
    logic             w_row = 1'b0;
    logic [CW-1:0]    w_ch = '0;
    logic [WW-1:0]    w_data = '0;
    logic             w_err;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [XV-1:0]    x_data = '0;
    logic             bank_sel = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [ACC_W-1:0] out_data;
    logic             busy;

    oai_mac_array #(.WW(WW), .N_CH(N_CH), .XW(XW)) dut (
        .clk(clk), .rst_n(rst_n),
        .w_we(w_we), .w_row(w_row), .w_ch(w_ch), .w_data(w_data), .w_err(w_err),
        .in_valid(in_valid), .in_ready(in_ready), .x_data(x_data), .bank_sel(bank_sel),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { longint data; int vcyc; } exp_t;
    typedef struct { int cyc; bit row; int ch; int val; } wr_t;

    exp_t   sb[$];
    wr_t    wr_q[$];
    int     wm [2][N_CH];
    int     cyc = 0;
    int     n_checks = 0;
    int     n_errs = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic longint model(input logic [XV-1:0] x, input bit bank);
        longint s = 0;
        for (int i = 0; i < N_CH; i++)
            s += longint'(wm[bank][i]) * longint'(x[i*XW +: XW]);
        return s;
    endfunction

    function automatic int lat_of(input logic [XV-1:0] x);
`ifdef OAI_MAC_ZSKIP_EN
        if (x == '0) return 1;
`endif
        return XW + 1;
    endfunction

    function automatic logic [XV-1:0] rand_x();
        logic [XV-1:0] v = '0;
        for (int i = 0; i < N_CH; i++) v[i*XW +: XW] = XW'($urandom);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_idle(input bit row, input int ch, input int val);
        w_we = 1'b1; w_row = row; w_ch = CW'(ch); w_data = WW'(val);
        tick();
        w_we = 1'b0;
        check("w_err_idle", longint'(w_err), 0);
        wm[row][ch] = val;
    endtask

    // One operation: accept, optional stall before out_ready, queued writes at given cycle offsets.
    task automatic do_op(input logic [XV-1:0] x, input bit bank, input int stall, input longint want);
        int     lat;
        int     guard;
        bit     drop;
        bit     found;
        longint exp;
        lat = lat_of(x);
        in_valid = 1'b1; x_data = x; bank_sel = bank; out_ready = 1'b0;
        guard = 0;
        while (!in_ready && guard < 30) begin
            tick();
            guard++;
        end
        check("accept_wait", longint'(guard), 0);
        if (!in_ready) begin
            in_valid = 1'b0;
            wr_q.delete();
            return;
        end
        exp = (want >= 0) ? want : model(x, bank);
        for (int c = 0; c <= lat + stall; c++) begin
            if (c > 0) begin
                in_valid = (stall > 0) ? 1'b1 : 1'($urandom);
                x_data   = rand_x();
                bank_sel = 1'($urandom);
            end
            out_ready = (c >= lat + stall);
            drop = 1'b0;
            found = 1'b0;
            w_we = 1'b0;
            for (int j = 0; j < wr_q.size(); j++) begin
                if (!found && wr_q[j].cyc == c) begin
                    found  = 1'b1;
                    w_we   = 1'b1;
                    w_row  = wr_q[j].row;
                    w_ch   = CW'(wr_q[j].ch);
                    w_data = WW'(wr_q[j].val);
                    drop   = (wr_q[j].row == bank);
                    if (!drop) wm[wr_q[j].row][wr_q[j].ch] = wr_q[j].val;
                end
            end
            tick();
            if (c == 0) sb.push_back('{exp, cyc + lat - 1});
            w_we = 1'b0;
            check("w_err", longint'(w_err), longint'(drop));
            if (c < lat + stall) begin
                check("in_ready_busy", longint'(in_ready), 0);
                check("busy_high", longint'(busy), 1);
            end else begin
                check("in_ready_idle", longint'(in_ready), 1);
                check("busy_low", longint'(busy), 0);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        wr_q.delete();
    endtask

    // Monitor: latency, hold stability, single-cycle valid and result data against the scoreboard.
    bit               pv = 1'b0;
    bit               ph = 1'b0;
    logic [ACC_W-1:0] pd = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            pv = 1'b0;
            ph = 1'b0;
        end else begin
            if (ph) check("valid_drop", longint'(out_valid), 0);
            if (out_valid && !pv) begin
                if (sb.size() == 0) check("spurious_valid", 1, 0);
                else check("latency_cycle", longint'(cyc), longint'(sb[0].vcyc));
            end
            if (out_valid && pv && !ph) check("hold_stable", longint'(out_data), longint'(pd));
            if (out_valid && out_ready && sb.size() > 0) begin
                check("result", longint'(out_data), sb[0].data);
                void'(sb.pop_front());
            end
            pv = out_valid;
            pd = out_data;
            ph = out_valid && out_ready;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [XV-1:0] xv;
        int            lat;
        int            st;
        int            ca;
        int            cb;
        bit            bk;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N_CH; i++) wm[r][i] = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", longint'(in_ready), 0);
        check("rst_out_valid", longint'(out_valid), 0);
        check("rst_out_data", longint'(out_data), 0);
        check("rst_busy", longint'(busy), 0);
        check("rst_w_err", longint'(w_err), 0);
        rst_n = 1'b1;
        check("in_ready_pre_edge", longint'(in_ready), 0);
        tick();
        check("in_ready_post_edge", longint'(in_ready), 1);

        // Full scale
        for (int i = 0; i < N_CH; i++) write_idle(1'b0, i, 4095);
        do_op({N_CH{XW'(255)}}, 1'b0, 0, 8353800);

        // Bank selection
        for (int i = 0; i < N_CH; i++) begin
            write_idle(1'b0, i, i + 1);
            write_idle(1'b1, i, 100);
        end
        do_op({N_CH{XW'(2)}}, 1'b1, 0, 1600);
        do_op({N_CH{XW'(2)}}, 1'b0, 0, 72);

        // Backpressure, then an immediate second accept
        do_op({N_CH{XW'(2)}}, 1'b0, 5, 72);
        do_op({N_CH{XW'(2)}}, 1'b1, 0, 1600);

        // Write collision: row0 dropped, row1 applied
        wr_q.push_back('{3, 1'b0, 0, 7});
        wr_q.push_back('{5, 1'b1, 0, 7});
        do_op({N_CH{XW'(2)}}, 1'b0, 0, 72);
        xv = '0;
        xv[0 +: XW] = XW'(1);
        do_op(xv, 1'b1, 0, 7);

        // Reset during COMPUTE
        in_valid = 1'b1; x_data = {N_CH{XW'(255)}}; bank_sel = 1'b0; out_ready = 1'b1;
        check("rst_op_ready", longint'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", longint'(out_valid), 0);
        check("abort_in_ready", longint'(in_ready), 0);
        check("abort_busy", longint'(busy), 0);
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < N_CH; i++) wm[r][i] = 0;
        tick();
        rst_n = 1'b1;
        repeat (12) tick();
        check("post_abort_busy", longint'(busy), 0);
        do_op({N_CH{XW'(255)}}, 1'b0, 0, 0);

        // All-zero activations
        do_op('0, 1'b0, 0, 0);
        do_op('0, 1'b1, 2, 0);

        // Randomized operations with interleaved weight writes
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 2) == 0)
                write_idle(1'($urandom), $urandom_range(0, N_CH - 1), $urandom_range(0, 4095));
            xv  = ($urandom_range(0, 7) == 0) ? '0 : rand_x();
            bk  = 1'($urandom);
            st  = $urandom_range(0, 3);
            lat = lat_of(xv);
            if ($urandom_range(0, 2) != 0) begin
                ca = $urandom_range(0, lat + st);
                wr_q.push_back('{ca, 1'($urandom), $urandom_range(0, N_CH - 1), $urandom_range(0, 4095)});
                cb = (ca + 1) % (lat + st + 1);
                if (cb != ca && $urandom_range(0, 1) == 1)
                    wr_q.push_back('{cb, 1'($urandom), $urandom_range(0, N_CH - 1), $urandom_range(0, 4095)});
            end
            do_op(xv, bk, st, -1);
        end

        repeat (4) tick();
        check("scoreboard_empty", longint'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/oai_mac_array.md
# oai_mac_array

Parametrised bit-serial multiply-accumulate engine built on per-channel 12-bit-style OAI bit multipliers for the DCIM macro. It holds two weight rows per channel, streams activations MSB-first one bit per cycle, and reduces all channel products through an adder tree into a shift-accumulator. A valid/ready handshake sits on both the input and the output. Weight rows can be rewritten while the other row is computing.

## Interface
- `WW`, 12, weight width per channel.
- `N_CH`, 8, number of channels.
- `XW`, 8, activation width in bits. This is also the number of compute cycles.
- `ACC_W`, `WW+XW+$clog2(N_CH)`, output and accumulator width.

Ports (reset is asynchronous, active-low; single clock):
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `w_we`  in  1  weight write strobe.
- `w_row`  in  1  target row (0/1).
- `w_ch`  in  `$clog2(N_CH)`  target channel.
- `w_data`  in  `WW`  weight value (unsigned).
- `w_err`  out  1  one-cycle pulse when a write is dropped.
- `in_valid`  in  1  activation vector valid.
- `in_ready`  out  1  block can accept a vector.
- `x_data`  in  `N_CH*XW`  activations; channel i occupies `[i*XW +: XW]`, unsigned.
- `bank_sel`  in  1  weight row used for this operation; sampled with `x_data`.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_data`  out  `ACC_W`  result equal to `sum_i W[bank_sel][i]*x_i`.
- `busy`  out  1  high in COMPUTE or DONE.

## Operation
**Weight storage**
- Weights are stored inverted: `~w_data`.
- Reset sets every stored word to all-ones, which means every weight is 0.

**OAI bit product** for channel i at step k:
- `e = ~((a|c)&(b|d))`
- `a = bank_q ? '1 : ~W0_i` (stored form)
- `b = bank_q ? ~W1_i : '1`
- `c = d = {WW{~x_i[k]}}`
- This yields `e = W[bank_q]_i & {WW{x_i[k]}}`.

**Adder tree**
- Sums the `N_CH` OAI outputs combinationally.
- Width is `WW+$clog2(N_CH)`, zero-extended to `ACC_W`.

**State machine**
- **IDLE:**
  - `in_ready=1`.
  - On `in_valid&&in_ready`: capture `x_data` into a shift register and `bank_sel` into `bank_q`; clear `acc`; set `k=XW-1`; go to COMPUTE.
- **COMPUTE:**
  - Each cycle: `acc <= (acc<<1) + tree(k)`, then decrement `k`.
  - After the step with `k==0`: load `out_data<=acc_next`, assert `out_valid`, go to DONE.
- **DONE:**
  - Hold `out_valid` and `out_data` stable until `out_ready`.
  - On `out_valid&&out_ready`: deassert `out_valid`, go to IDLE.
  - `in_ready=0`; there is no result/accept overlap.

**Weight writes**
- Accepted in any state, and take effect at the next edge.
- A write with `w_row==bank_q` while `busy` is dropped: no state change and `w_err` pulses for one cycle.
- Writes to the other row are always applied.
- Writes while IDLE are always applied.

**Arithmetic**
- Unsigned throughout.
- `ACC_W` is sized so that no overflow occurs (max 8,353,800 < 2^23 at default parameters).

## Timing
**Reset values**
- `in_ready=0` while `rst_n` is low, and 1 from the first edge after release.
- `out_valid=0`, `out_data=0`, `busy=0`, `w_err=0`.
- State is IDLE.
- All weights are 0.

**Latency**
- `out_valid` rises `XW+1` edges after the accept edge (9 cycles at default).
- Throughput is one result per `XW+2` cycles when `out_ready` is held high.

**Handshake rules**
- `x_data` and `bank_sel` are only sampled on the accept edge; they may change afterwards.
- Holding `out_ready` low stalls the block indefinitely, with no loss of data.

**Edge cases**
- **Reset asserted mid-COMPUTE or DONE:** the operation is aborted immediately, outputs return to reset values, and weights are cleared.
- **`w_we` on the same edge as accept:** the write is checked against the newly captured `bank_q`.

## Configuration
- `OAI_MAC_ZSKIP_EN` defined:
  - On accept, if `x_data==0`, go directly to DONE with `out_data=0`.
  - `out_valid` rises 1 edge after accept; COMPUTE is skipped.
  - `busy` is high for the DONE period only.
- `OAI_MAC_ZSKIP_EN` undefined:
  - An all-zero vector takes the normal `XW+1` latency and produces 0.

## Test plan
1. **Full-scale result:** All W0=4095, all x=255, `bank_sel=0`, `out_ready=1` -> `out_data=8353800`, with `out_valid` 9 cycles after accept and high for exactly 1 cycle.
2. **Bank selection:** W0_i=i+1, W1_i=100, all x=2:
   - `bank_sel=1` -> 1600.
   - Next operation with `bank_sel=0` -> 72.
3. **Backpressure:** Hold `out_ready=0` for 5 cycles after `out_valid` -> `out_data` stable, `in_ready=0`, a second `in_valid` is not accepted; raise `out_ready` -> IDLE next cycle, then the second vector is accepted.
4. **Write collision:**
   - During COMPUTE with `bank_q=0`, write row0 ch0=7 -> dropped, `w_err` pulses for 1 cycle, and the result is unchanged.
   - In the same operation, write row1 ch0=7 -> applied; the next `bank_sel=1` operation with `x_0=1` and all other x=0 returns 7.
5. **Reset mid-operation:** Pulse `rst_n` low in COMPUTE cycle 4 -> `out_valid` never rises; after release, all x=255 with `bank_sel=0` returns 0 because the weights were cleared.
6. **Zero-skip behaviour:** All x=0:
   - With `OAI_MAC_ZSKIP_EN` -> `out_valid` 1 cycle after accept, `out_data=0`.
   - Without `OAI_MAC_ZSKIP_EN` -> 9 cycles, `out_data=0`.
